// File: rtl/id_frame_pkg.sv
// id_frame_pkg: shared definitions for the stack chip-ID assignment frame.
// Used by id_frame_responder, id_frame_check and the self-test sequencer.
package id_frame_pkg;

  // Fixed frame constants
  localparam logic [3:0]  FRAME_HEADER = 4'hA;
  localparam logic [15:0] FRAME_MARKER = 16'hBEEF;

  // Field bit positions, MSB first: header | power | sender | offered | marker
  localparam int HDR_MSB = 31;
  localparam int HDR_LSB = 28;
  localparam int PWR_MSB = 27;
  localparam int PWR_LSB = 24;
  localparam int SND_MSB = 23;
  localparam int SND_LSB = 20;
  localparam int OFF_MSB = 19;
  localparam int OFF_LSB = 16;
  localparam int MRK_MSB = 15;
  localparam int MRK_LSB = 0;

  // Responder handshake states
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_TURN   = 2'd1,
    ST_ACK    = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  // Assemble a complete frame word from its variable fields
  function automatic logic [31:0] build_frame(input logic [3:0] power,
                                              input logic [3:0] sender_id,
                                              input logic [3:0] offered_id);
    return {FRAME_HEADER, power, sender_id, offered_id, FRAME_MARKER};
  endfunction

endpackage

// File: rtl/id_frame_check.sv
// id_frame_check: combinational decode of a received ID-assignment word.
// A word is marked when qualified and carrying the marker; a marked word is
// valid when its header matches and it offers sender+1 without wrapping to 0.
module id_frame_check
  import id_frame_pkg::*;
(
  input  logic        rx_valid_i,
  input  logic [31:0] rx_data_i,
  output logic        frame_valid_o,
  output logic        frame_reject_o,
  output logic [3:0]  offered_id_o,
  output logic [3:0]  power_o
);

  logic       marked;
  logic       fields_ok;
  logic [3:0] sender_id;

  assign sender_id    = rx_data_i[SND_MSB:SND_LSB];
  assign offered_id_o = rx_data_i[OFF_MSB:OFF_LSB];
  assign power_o      = rx_data_i[PWR_MSB:PWR_LSB];

  assign marked    = rx_valid_i && (rx_data_i[MRK_MSB:MRK_LSB] == FRAME_MARKER);
  // Offer must be exactly sender+1 in 4 bits; a wrap from F to 0 is illegal
  assign fields_ok = (rx_data_i[HDR_MSB:HDR_LSB] == FRAME_HEADER) &&
                     (offered_id_o == sender_id + 4'd1) &&
                     (offered_id_o != 4'h0);

  assign frame_valid_o  = marked && fields_ok;
  assign frame_reject_o = marked && !fields_ok;

endmodule

// File: rtl/id_frame_responder.sv
// id_frame_responder: upper-layer end of the chip-ID assignment handshake.
// Adopts the ID offered by the layer below, acks it after a fixed turnaround,
// then holds it, re-acking initiator retries of the same ID.
// Optional build macro: ID_RESP_ERRCNT_EN adds an 8-bit saturating err_count
// output counting frame_err pulses.
module id_frame_responder
  import id_frame_pkg::*;
#(
  parameter int TURNAROUND = 4,  // 0..15 idle cycles before the ack
  parameter int ACK_LEN    = 2   // 1..4 cycles of tx_valid per ack
) (
  input  logic        div_8_clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  output logic [3:0]  chip_id,
  output logic        id_valid,
  output logic [3:0]  power_level,
  output logic        frame_err
`ifdef ID_RESP_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND);
  localparam logic [1:0] ACK_LOAD  = 2'(ACK_LEN - 1);

  state_e      state_q;
  logic [3:0]  turn_cnt_q;
  logic [1:0]  ack_cnt_q;
  logic        tx_valid_q;
  logic [31:0] tx_data_q;
  logic [3:0]  chip_id_q;
  logic        id_valid_q;
  logic [3:0]  power_q;
  logic        frame_err_q;
  logic        frame_err_d;

  logic        frame_valid;
  logic        frame_reject;
  logic [3:0]  offered_id;
  logic [3:0]  frame_power;

  id_frame_check u_check (
    .rx_valid_i    (rx_valid),
    .rx_data_i     (rx_data),
    .frame_valid_o (frame_valid),
    .frame_reject_o(frame_reject),
    .offered_id_o  (offered_id),
    .power_o       (frame_power)
  );

  // Rejects count only while listening: malformed frames in HUNT or LOCKED,
  // and in LOCKED any valid frame offering an ID other than the adopted one
  always_comb begin
    frame_err_d = 1'b0;
    if (state_q == ST_HUNT) begin
      frame_err_d = frame_reject;
    end else if (state_q == ST_LOCKED) begin
      frame_err_d = frame_reject || (frame_valid && (offered_id != chip_id_q));
    end
  end

  // Handshake FSM with all outputs registered; reset aborts any ack at once
  always_ff @(posedge div_8_clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      turn_cnt_q  <= 4'd0;
      ack_cnt_q   <= 2'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 32'd0;
      chip_id_q   <= 4'd0;
      id_valid_q  <= 1'b0;
      power_q     <= 4'd0;
      frame_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge
      // values, so statement order inside this block does not matter.
      frame_err_q <= frame_err_d;
      case (state_q)
        ST_HUNT: begin
          if (frame_valid) begin
            chip_id_q  <= offered_id;
            power_q    <= frame_power;
            id_valid_q <= 1'b1;
            turn_cnt_q <= TURN_LOAD;
            state_q    <= ST_TURN;
          end
        end
        ST_TURN: begin
          if (turn_cnt_q == 4'd0) begin
            ack_cnt_q  <= ACK_LOAD;
            tx_valid_q <= 1'b1;
            tx_data_q  <= build_frame(power_q, chip_id_q, chip_id_q + 4'd1);
            state_q    <= ST_ACK;
          end else begin
            turn_cnt_q <= turn_cnt_q - 4'd1;
          end
        end
        ST_ACK: begin
          if (ack_cnt_q == 2'd0) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 32'd0;
            state_q    <= ST_LOCKED;
          end else begin
            ack_cnt_q <= ack_cnt_q - 2'd1;
          end
        end
        ST_LOCKED: begin
          // Retry of the adopted ID at a new power level: re-ack it
          if (frame_valid && (offered_id == chip_id_q)) begin
            power_q    <= frame_power;
            turn_cnt_q <= TURN_LOAD;
            state_q    <= ST_TURN;
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

`ifdef ID_RESP_ERRCNT_EN
  logic [7:0] err_count_q;

  // Saturating tally of rejected frames, stuck at 255 once full
  always_ff @(posedge div_8_clk) begin
    if (rst) begin
      err_count_q <= 8'd0;
    end else if (frame_err_d && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`endif

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign chip_id     = chip_id_q;
  assign id_valid    = id_valid_q;
  assign power_level = power_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_id_frame_responder.sv
// tb_id_frame_responder: directed plus randomized checks of id_frame_responder
// against a cycle-count reference model. Honours ID_RESP_ERRCNT_EN.
module tb_id_frame_responder;

  localparam int TA = 4;
  localparam int AL = 2;

  logic        div_8_clk = 1'b0;
  logic        rst       = 1'b1;
  logic        rx_valid  = 1'b0;
  logic [31:0] rx_data   = 32'd0;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic [3:0]  chip_id;
  logic        id_valid;
  logic [3:0]  power_level;
  logic        frame_err;
`ifdef ID_RESP_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  always #5 div_8_clk = ~div_8_clk;

  id_frame_responder #(.TURNAROUND(TA), .ACK_LEN(AL)) dut (
    .div_8_clk  (div_8_clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .chip_id    (chip_id),
    .id_valid   (id_valid),
    .power_level(power_level),
    .frame_err  (frame_err)
`ifdef ID_RESP_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edge counter plus the edge windows of the pending ack
  int         cyc      = 0;
  int         ack_lo   = -10;
  int         ack_hi   = -20;
  int         busy_end = 0;
  bit         m_idv    = 1'b0;
  logic [3:0] m_id     = 4'd0;
  logic [3:0] m_pwr    = 4'd0;
  bit         m_err    = 1'b0;
  int         m_errcnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Apply the frame rules to one clock edge
  task automatic model_edge(input logic r, input logic v, input logic [31:0] d);
    logic [3:0] hdr, pw, snd, off;
    bit marked, ok;
    cyc++;
    m_err = 1'b0;
    if (r) begin
      m_idv = 1'b0; m_id = 4'd0; m_pwr = 4'd0;
      ack_lo = -10; ack_hi = -20; busy_end = cyc; m_errcnt = 0;
    end else if (v && cyc > busy_end) begin
      hdr = d[31:28]; pw = d[27:24]; snd = d[23:20]; off = d[19:16];
      marked = (d[15:0] == 16'hBEEF);
      ok = marked && hdr == 4'hA && off == 4'(snd + 4'd1) && off != 4'h0;
      if (ok && (!m_idv || off == m_id)) begin
        m_idv    = 1'b1;
        m_id     = off;
        m_pwr    = pw;
        ack_lo   = cyc + 1 + TA;
        ack_hi   = cyc + TA + AL;
        busy_end = cyc + 1 + TA + AL;
      end else if (marked) begin
        m_err = 1'b1;
        if (m_errcnt < 255) m_errcnt++;
      end
    end
  endtask

  // Drive one cycle, advance the model, then compare every output
  task automatic step(input logic r, input logic v, input logic [31:0] d);
    bit in_ack;
    logic [31:0] exp_tx;
    @(negedge div_8_clk);
    rst = r; rx_valid = v; rx_data = d;
    @(posedge div_8_clk);
    model_edge(r, v, d);
    #1;
    in_ack = (cyc >= ack_lo) && (cyc <= ack_hi);
    exp_tx = in_ack ? {4'hA, m_pwr, m_id, 4'(m_id + 4'd1), 16'hBEEF} : 32'd0;
    check("tx_valid",    32'(tx_valid),    32'(in_ack));
    check("tx_data",     tx_data,          exp_tx);
    check("chip_id",     32'(chip_id),     32'(m_id));
    check("id_valid",    32'(id_valid),    32'(m_idv));
    check("power_level", 32'(power_level), 32'(m_pwr));
    check("frame_err",   32'(frame_err),   32'(m_err));
`ifdef ID_RESP_ERRCNT_EN
    check("err_count",   32'(err_count),   32'(m_errcnt));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    int sel;
    logic [3:0] s;
    logic [31:0] w;

    // Reset state
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);

    // Bad header in HUNT: one-cycle error, no adoption, no ack
    step(1'b0, 1'b1, 32'h5312BEEF);
    check("bad_hdr_err", 32'(frame_err), 32'd1);
    idle(1);
    check("bad_hdr_err_clr", 32'(frame_err), 32'd0);
    idle(8);

    // Offered ID wrapping to 0 is rejected; a legal F offer is adopted
    step(1'b0, 1'b1, 32'hA1F0BEEF);
    check("wrap_err", 32'(frame_err), 32'd1);
    idle(2);
    step(1'b0, 1'b1, 32'hA1EFBEEF);
    idle(TA + 1);
    check("wrap_ack", tx_data, 32'hA1F0BEEF);
    idle(AL + 2);

    // Basic adoption with default timing
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'hA312BEEF);
    check("adopt_id", 32'(chip_id), 32'd2);
    idle(TA);
    check("pre_ack_low", 32'(tx_valid), 32'd0);
    idle(1);
    check("ack_word0", tx_data, 32'hA323BEEF);
    idle(1);
    check("ack_word1", tx_data, 32'hA323BEEF);
    idle(1);
    check("ack_end", 32'(tx_valid), 32'd0);
    idle(2);

    // LOCKED: retry at higher power re-acks, different ID is rejected
    step(1'b0, 1'b1, 32'hA712BEEF);
    check("retry_pwr", 32'(power_level), 32'd7);
    idle(TA + 1);
    check("reack_word", tx_data, 32'hA723BEEF);
    idle(AL + 1);
    step(1'b0, 1'b1, 32'hA734BEEF);
    check("locked_err", 32'(frame_err), 32'd1);
    check("locked_keep_id", 32'(chip_id), 32'd2);
    idle(3);

    // Reset in the first ACK cycle aborts the ack
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'hA312BEEF);
    idle(TA + 1);
    check("ack_started", 32'(tx_valid), 32'd1);
    step(1'b1, 1'b0, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    idle(AL + 2);
    step(1'b0, 1'b1, 32'hA445BEEF);
    check("rehunt_id", 32'(chip_id), 32'd5);
    idle(TA + AL + 2);

`ifdef ID_RESP_ERRCNT_EN
    // Error counter saturates at 255
    step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 32'h5312BEEF);
    check("errcnt_sat", 32'(err_count), 32'd255);
`endif

    // Randomized traffic: noise, marked junk, fresh offers and retries
    step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 1500; i++) begin
      sel = int'($urandom_range(0, 9));
      s   = 4'($urandom);
      case (sel)
        0:       w = $urandom;
        1:       w = {16'($urandom), 16'hBEEF};
        2, 3:    w = {4'hA, 4'($urandom), s, 4'(s + 4'd1), 16'hBEEF};
        4, 5:    w = {4'hA, 4'($urandom), 4'(m_id - 4'd1), m_id, 16'hBEEF};
        default: w = 32'd0;
      endcase
      step(($urandom_range(0, 199) == 0), (sel < 6), w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
